// File: rtl/ov7670_gerador.sv
// ---------------------------------------------------------------------------
// ov7670_gerador
// Transmitting end of an OV7670-style camera link. It generates the
// VSYNC / HREF / byte-strobe timing of one frame, or of back-to-back frames,
// so that a capture path can be brought up without a real sensor.
//
// Frame sequence:
//   pulso_vsync -> vblank -> { linha_ativa -> hblank } x LINHAS -> fim
//
// Ports
//   clock           system clock; all state changes on its rising edge
//   reset           asynchronous, active-low
//   iniciar         starts a frame when sampled high while idle
//   continuo        high at end of frame: the next frame follows immediately
//   padrao          0 = incrementing byte count, 1 = constant RGB565 colour
//   cor             RGB565 colour, sampled at the start of each byte slot
//   VSYNC           frame sync, high during the VSYNC pulse
//   HREF            high while active line bytes are driven
//   dados           byte value, held for the whole byte slot; 0 outside lines
//   transmite_byte  strobe in the last cycle of each byte slot
//   fim_frame       one-cycle pulse after the last line blanking
//   ocupado         high whenever a frame is in progress
//   db_estado       current state code; 1111 for an unused code
// ---------------------------------------------------------------------------
module ov7670_gerador #(
    parameter int LINHAS        = 4,
    parameter int COLUNAS       = 4,
    parameter int DIV_PCLK      = 2,
    parameter int VSYNC_CICLOS  = 4,
    parameter int HBLANK_CICLOS = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        iniciar,
    input  logic        continuo,
    input  logic        padrao,
    input  logic [15:0] cor,
    output logic        VSYNC,
    output logic        HREF,
    output logic [7:0]  dados,
    output logic        transmite_byte,
    output logic        fim_frame,
    output logic        ocupado,
    output logic [3:0]  db_estado
);

    typedef enum logic [3:0] {
        INICIAL     = 4'b0000,
        PULSO_VSYNC = 4'b0001,
        VBLANK      = 4'b0010,
        LINHA_ATIVA = 4'b0011,
        HBLANK      = 4'b0100,
        FIM         = 4'b0101
    } estado_t;

    // Terminal values of each counter, sized to the counter they compare with.
    localparam logic [7:0] VSYNC_FIM  = 8'(VSYNC_CICLOS - 1);
    localparam logic [7:0] HBLANK_FIM = 8'(HBLANK_CICLOS - 1);
    localparam logic [7:0] LINHA_FIM  = 8'(LINHAS - 1);
    localparam logic [8:0] BYTE_FIM   = 9'(COLUNAS * 2 - 1);
    localparam logic [3:0] CICLO_FIM  = 4'(DIV_PCLK - 1);

    estado_t     r_estado, w_prox;
    logic [7:0]  r_cont,   w_cont;    // cycles spent in vsync / blanking
    logic [7:0]  r_linha,  w_linha;   // active line index
    logic [8:0]  r_byte,   w_byte;    // byte index within the line
    logic [3:0]  r_ciclo,  w_ciclo;   // cycle within the byte slot
    logic [7:0]  r_valor,  w_valor;   // bytes sent so far this frame, mod 256

    logic        r_vsync, r_href, r_strobe, r_fim, r_ocupado;
    logic [7:0]  r_dados;
    logic        w_inicio_slot;

    // Next-state and counter update.
    // NOTE: every signal gets a default before the case, so no path leaves a
    // value unassigned and no latch can be inferred.
    always_comb begin
        w_prox  = r_estado;
        w_cont  = r_cont;
        w_linha = r_linha;
        w_byte  = r_byte;
        w_ciclo = r_ciclo;
        w_valor = r_valor;

        case (r_estado)
            INICIAL: begin
                if (iniciar) begin
                    w_prox = PULSO_VSYNC;
                    w_cont = '0;
                end
            end
            PULSO_VSYNC: begin
                if (r_cont == VSYNC_FIM) begin
                    w_prox = VBLANK;
                    w_cont = '0;
                end else begin
                    w_cont = r_cont + 8'd1;
                end
            end
            VBLANK: begin
                if (r_cont == HBLANK_FIM) begin
                    w_prox  = LINHA_ATIVA;
                    w_linha = '0;
                    w_byte  = '0;
                    w_ciclo = '0;
                    w_valor = '0;
                end else begin
                    w_cont = r_cont + 8'd1;
                end
            end
            LINHA_ATIVA: begin
                if (r_ciclo == CICLO_FIM) begin
                    // End of a byte slot: the running value also advances
                    // across line boundaries, giving line*COLUNAS*2 + index.
                    w_ciclo = '0;
                    w_valor = r_valor + 8'd1;
                    if (r_byte == BYTE_FIM) begin
                        w_prox = HBLANK;
                        w_cont = '0;
                    end else begin
                        w_byte = r_byte + 9'd1;
                    end
                end else begin
                    w_ciclo = r_ciclo + 4'd1;
                end
            end
            HBLANK: begin
                if (r_cont == HBLANK_FIM) begin
                    if (r_linha != LINHA_FIM) begin
                        w_prox  = LINHA_ATIVA;
                        w_linha = r_linha + 8'd1;
                        w_byte  = '0;
                        w_ciclo = '0;
                    end else begin
                        w_prox = FIM;
                    end
                end else begin
                    w_cont = r_cont + 8'd1;
                end
            end
            FIM: begin
                w_prox  = continuo ? PULSO_VSYNC : INICIAL;
                w_cont  = '0;
                w_linha = '0;
                w_byte  = '0;
                w_ciclo = '0;
                w_valor = '0;
            end
            default: begin
                // Unused code: recover to idle with everything cleared.
                w_prox  = INICIAL;
                w_cont  = '0;
                w_linha = '0;
                w_byte  = '0;
                w_ciclo = '0;
                w_valor = '0;
            end
        endcase
    end

    // A new slot begins whenever the line is active with slot cycle 0; the
    // byte is latched only here, so padrao/cor never mix within one slot.
    assign w_inicio_slot = (w_prox == LINHA_ATIVA) && (w_ciclo == 4'd0);

    // NOTE: state and outputs use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_estado  <= INICIAL;
            r_cont    <= '0;
            r_linha   <= '0;
            r_byte    <= '0;
            r_ciclo   <= '0;
            r_valor   <= '0;
            r_vsync   <= 1'b0;
            r_href    <= 1'b0;
            r_strobe  <= 1'b0;
            r_fim     <= 1'b0;
            r_ocupado <= 1'b0;
            r_dados   <= 8'h00;
        end else begin
            r_estado  <= w_prox;
            r_cont    <= w_cont;
            r_linha   <= w_linha;
            r_byte    <= w_byte;
            r_ciclo   <= w_ciclo;
            r_valor   <= w_valor;
            // Outputs are registered from the next state so they line up
            // exactly with the state they describe.
            r_vsync   <= (w_prox == PULSO_VSYNC);
            r_href    <= (w_prox == LINHA_ATIVA);
            r_strobe  <= (w_prox == LINHA_ATIVA) && (w_ciclo == CICLO_FIM);
            r_fim     <= (w_prox == FIM);
            r_ocupado <= (w_prox != INICIAL);
            if (w_prox != LINHA_ATIVA) begin
                r_dados <= 8'h00;
            end else if (w_inicio_slot) begin
                // Byte parity equals w_valor parity: each line starts on an
                // even running count.
                if (padrao) begin
                    r_dados <= w_valor[0] ? cor[7:0] : cor[15:8];
                end else begin
                    r_dados <= w_valor;
                end
            end
        end
    end

    always_comb begin
        case (r_estado)
            INICIAL, PULSO_VSYNC, VBLANK, LINHA_ATIVA, HBLANK, FIM:
                db_estado = r_estado;
            default:
                db_estado = 4'b1111;
        endcase
    end

    assign VSYNC          = r_vsync;
    assign HREF           = r_href;
    assign dados          = r_dados;
    assign transmite_byte = r_strobe;
    assign fim_frame      = r_fim;
    assign ocupado        = r_ocupado;

endmodule

// File: tb/tb_ov7670_gerador.sv
// ---------------------------------------------------------------------------
// tb_ov7670_gerador
// Scoreboard bench for ov7670_gerador. Stimulus tasks start frames with a
// random pattern/colour and push the expected VSYNC rise cycles, strobed
// bytes and fim_frame cycles into queues; monitor processes pop and compare
// whenever the DUT presents the corresponding event. A second instance with
// the smallest geometry (1 line, 1 pixel, 1 cycle per byte) is checked with
// its own queue of (cycle, byte) pairs.
// ---------------------------------------------------------------------------
module tb_ov7670_gerador;

    localparam int L  = 4;
    localparam int C  = 4;
    localparam int D  = 2;
    localparam int V  = 4;
    localparam int H  = 3;
    localparam int FRAME_LEN = V + H + L * (C * 2 * D + H) + 1;
    localparam int MIN_LEN   = V + 2 * H + 3;

    typedef struct {
        int         ciclo;
        logic [7:0] valor;
    } strobe_t;

    logic        clock, reset;
    logic        iniciar, continuo, padrao;
    logic [15:0] cor;
    logic        VSYNC, HREF, transmite_byte, fim_frame, ocupado;
    logic [7:0]  dados;
    logic [3:0]  db_estado;

    logic        iniciar2;
    logic        VSYNC2, HREF2, strobe2, fim2, ocupado2;
    logic [7:0]  dados2;
    logic [3:0]  db2;

    int cyc = 0;
    int n_checks = 0;
    int n_erros  = 0;

    int          q_vs[$];
    logic [7:0]  q_bytes[$];
    int          q_fim[$];
    strobe_t     q2_strobe[$];
    int          q2_fim[$];

    ov7670_gerador #(
        .LINHAS(L), .COLUNAS(C), .DIV_PCLK(D),
        .VSYNC_CICLOS(V), .HBLANK_CICLOS(H)
    ) u_dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .continuo(continuo),
        .padrao(padrao), .cor(cor), .VSYNC(VSYNC), .HREF(HREF), .dados(dados),
        .transmite_byte(transmite_byte), .fim_frame(fim_frame),
        .ocupado(ocupado), .db_estado(db_estado)
    );

    ov7670_gerador #(
        .LINHAS(1), .COLUNAS(1), .DIV_PCLK(1),
        .VSYNC_CICLOS(V), .HBLANK_CICLOS(H)
    ) u_min (
        .clock(clock), .reset(reset), .iniciar(iniciar2), .continuo(1'b0),
        .padrao(1'b0), .cor(16'h0000), .VSYNC(VSYNC2), .HREF(HREF2),
        .dados(dados2), .transmite_byte(strobe2), .fim_frame(fim2),
        .ocupado(ocupado2), .db_estado(db2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string nome, input logic [31:0] atual,
                         input logic [31:0] esperado);
        n_checks++;
        if (atual !== esperado) begin
            n_erros++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)",
                     nome, atual, esperado, cyc);
        end
    endtask

    task automatic falha(input string nome);
        n_checks++;
        n_erros++;
        $display("FAIL %s: event with no expectation (cycle %0d)", nome, cyc);
    endtask

    // Reference model: the whole frame as the camera would send it.
    task automatic empilhar_frame(input int t0, input logic p,
                                  input logic [15:0] c);
        logic [7:0] b;
        q_vs.push_back(t0 + 1);
        for (int l = 0; l < L; l++) begin
            for (int i = 0; i < 2 * C; i++) begin
                if (p) b = (i % 2 == 0) ? c[15:8] : c[7:0];
                else   b = 8'((l * C * 2 + i) % 256);
                q_bytes.push_back(b);
            end
        end
        q_fim.push_back(t0 + FRAME_LEN);
    endtask

    task automatic iniciar_frame(input logic p, input logic [15:0] c,
                                 output int t0);
        @(negedge clock);
        padrao  = p;
        cor     = c;
        iniciar = 1'b1;
        t0      = cyc;
        empilhar_frame(t0, p, c);
    endtask

    // Waits for all pending frames to end; iniciar toggles randomly until
    // lim_ini to show it is ignored mid-frame, continuo drops at lim_cont.
    task automatic esperar_fim(input int lim_ini, input int lim_cont);
        int guarda = 0;
        while ((q_fim.size() != 0 || q2_fim.size() != 0) && guarda < 2000) begin
            @(negedge clock);
            iniciar = (cyc < lim_ini) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (cyc >= lim_cont) continuo = 1'b0;
            guarda++;
        end
        iniciar = 1'b0;
        if (guarda >= 2000) falha("timeout_fim_frame");
    endtask

    // Monitor for the default-geometry instance.
    initial begin
        int vs_run = 0, href_run = 0, n_strobe = 0;
        logic vs_ant = 1'b0;
        forever begin
            @(negedge clock);
            if (!reset) begin
                vs_run = 0; href_run = 0; n_strobe = 0; vs_ant = 1'b0;
            end else begin
                if (VSYNC) begin
                    if (!vs_ant) begin
                        if (q_vs.size() == 0) falha("vsync_inesperado");
                        else check("vsync_subida_ciclo", cyc, q_vs.pop_front());
                        check("db_estado_vsync", db_estado, 4'b0001);
                        check("ocupado_vsync", ocupado, 1'b1);
                    end
                    vs_run++;
                end else if (vs_ant) begin
                    check("vsync_largura", vs_run, V);
                    vs_run = 0;
                end
                vs_ant = VSYNC;

                if (HREF) begin
                    href_run++;
                end else begin
                    if (href_run != 0) begin
                        check("href_largura", href_run, C * 2 * D);
                        check("strobes_por_linha", n_strobe, C * 2);
                        href_run = 0;
                        n_strobe = 0;
                    end
                    check("dados_fora_linha", dados, 8'h00);
                    check("strobe_fora_linha", transmite_byte, 1'b0);
                end

                if (transmite_byte) begin
                    n_strobe++;
                    if (q_bytes.size() == 0) falha("strobe_inesperado");
                    else check("byte_strobe", dados, q_bytes.pop_front());
                    check("db_estado_linha", db_estado, 4'b0011);
                end

                if (fim_frame) begin
                    if (q_fim.size() == 0) falha("fim_frame_inesperado");
                    else check("fim_frame_ciclo", cyc, q_fim.pop_front());
                    check("db_estado_fim", db_estado, 4'b0101);
                end
            end
        end
    end

    // Monitor for the minimum-geometry instance.
    initial begin
        strobe_t s;
        forever begin
            @(negedge clock);
            if (reset) begin
                if (strobe2) begin
                    if (q2_strobe.size() == 0) falha("min_strobe_inesperado");
                    else begin
                        s = q2_strobe.pop_front();
                        check("min_strobe_ciclo", cyc, s.ciclo);
                        check("min_byte", dados2, s.valor);
                    end
                end
                if (fim2) begin
                    if (q2_fim.size() == 0) falha("min_fim_inesperado");
                    else check("min_fim_ciclo", cyc, q2_fim.pop_front());
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0;
        logic p;
        logic [15:0] c;

        reset = 1'b1; iniciar = 1'b0; continuo = 1'b0; padrao = 1'b0;
        cor = 16'h0000; iniciar2 = 1'b0;
        #1 reset = 1'b0;
        #20;
        check("reset_vsync",   VSYNC, 1'b0);
        check("reset_href",    HREF, 1'b0);
        check("reset_strobe",  transmite_byte, 1'b0);
        check("reset_fim",     fim_frame, 1'b0);
        check("reset_ocupado", ocupado, 1'b0);
        check("reset_dados",   dados, 8'h00);
        check("reset_estado",  db_estado, 4'b0000);
        @(negedge clock);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        check("idle_sem_iniciar", ocupado, 1'b0);

        // Counting pattern, then F800, then random patterns and colours.
        for (int f = 0; f < 5; f++) begin
            if (f == 0)      begin p = 1'b0; c = 16'h0000; end
            else if (f == 1) begin p = 1'b1; c = 16'hF800; end
            else begin
                p = 1'($urandom_range(0, 1));
                c = 16'($urandom);
            end
            iniciar_frame(p, c, t0);
            esperar_fim(t0 + FRAME_LEN - 5, 0);
            @(negedge clock);
            check("volta_inicial_ocupado", ocupado, 1'b0);
            check("volta_inicial_estado", db_estado, 4'b0000);
        end

        // Back-to-back frames with continuo held through the first frame end.
        continuo = 1'b1;
        iniciar_frame(1'b0, 16'h0000, t0);
        empilhar_frame(t0 + FRAME_LEN, 1'b0, 16'h0000);
        esperar_fim(t0 + 2 * FRAME_LEN - 5, t0 + 100);
        @(negedge clock);
        check("continuo_fim_ocupado", ocupado, 1'b0);

        // Reset in the middle of line index 2.
        iniciar_frame(1'b1, 16'h07E0, t0);
        while (cyc < t0 + 1 + V + H + 2 * (C * 2 * D + H) + 5) begin
            @(negedge clock);
            iniciar = 1'b0;
        end
        check("href_antes_reset", HREF, 1'b1);
        #2 reset = 1'b0;
        #1;
        check("abort_vsync",   VSYNC, 1'b0);
        check("abort_href",    HREF, 1'b0);
        check("abort_strobe",  transmite_byte, 1'b0);
        check("abort_fim",     fim_frame, 1'b0);
        check("abort_ocupado", ocupado, 1'b0);
        check("abort_dados",   dados, 8'h00);
        check("abort_estado",  db_estado, 4'b0000);
        q_vs.delete();
        q_bytes.delete();
        q_fim.delete();
        repeat (3) @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            check("pos_reset_idle",
                  {VSYNC, HREF, transmite_byte, fim_frame, ocupado, dados},
                  13'h0);
            check("pos_reset_estado", db_estado, 4'b0000);
        end

        // Minimum geometry: two consecutive strobes, 00 then 01.
        @(negedge clock);
        iniciar2 = 1'b1;
        t0 = cyc;
        q2_strobe.push_back('{t0 + 1 + V + H, 8'h00});
        q2_strobe.push_back('{t0 + 2 + V + H, 8'h01});
        q2_fim.push_back(t0 + MIN_LEN);
        @(negedge clock);
        iniciar2 = 1'b0;
        esperar_fim(0, 0);
        @(negedge clock);
        check("min_volta_inicial", ocupado2, 1'b0);

        check("fila_vsync_vazia", q_vs.size(), 0);
        check("fila_bytes_vazia", q_bytes.size(), 0);
        check("fila_min_vazia",   q2_strobe.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_erros);
        $finish;
    end

endmodule

// File: doc/ov7670_gerador.md
OV7670_GERADOR -- requirements
Module: ov7670_gerador

Interface
REQ-001 Parameter LINHAS, default 4: active lines per frame, 1..255.
REQ-002 Parameter COLUNAS, default 4: pixels per line, 1..255; each pixel is 2 bytes.
REQ-003 Parameter DIV_PCLK, default 2: clock cycles per byte slot, 1..16.
REQ-004 Parameter VSYNC_CICLOS, default 4: VSYNC pulse width in clock cycles, 1..255.
REQ-005 Parameter HBLANK_CICLOS, default 3: blanking cycles after VSYNC and after every line, 1..255.
REQ-006 clock  in  1  single system clock; all state changes on its rising edge.
REQ-007 reset  in  1  asynchronous, active-low reset (reset = 0 forces reset state immediately).
REQ-008 iniciar  in  1  level; starts a frame when sampled high in state inicial.
REQ-009 continuo  in  1  when high at end of frame, next frame starts with no idle cycle.
REQ-010 padrao  in  1  0 = incrementing byte counter, 1 = constant colour from cor.
REQ-011 cor  in  16  RGB565 colour used when padrao = 1, sampled once per byte slot.
REQ-012 VSYNC  out  1  frame sync, high during pulso_vsync only.
REQ-013 HREF  out  1  high while active line bytes are driven.
REQ-014 dados  out  8  byte value, stable for the whole byte slot.
REQ-015 transmite_byte  out  1  one-cycle strobe in last cycle of each byte slot; receiver samples dados on it.
REQ-016 fim_frame  out  1  one-cycle pulse after last line blanking.
REQ-017 ocupado  out  1  high in every state except inicial.
REQ-018 db_estado  out  4  state code per REQ-020.

Function
REQ-019 Block is the transmitting end of the camera capture interface: it emulates OV7670 VSYNC/HREF/byte-strobe timing for bench and bring-up of the capture path.
REQ-020 States and codes: inicial 0000, pulso_vsync 0001, vblank 0010, linha_ativa 0011, hblank 0100, fim 0101; any unused code SHALL return to inicial next cycle with db_estado 1111.
REQ-021 inicial: iniciar = 1 -> pulso_vsync; else stay; iniciar ignored in all other states.
REQ-022 pulso_vsync lasts exactly VSYNC_CICLOS cycles, then vblank.
REQ-023 vblank lasts exactly HBLANK_CICLOS cycles, then linha_ativa with line counter = 0.
REQ-024 linha_ativa lasts exactly COLUNAS*2*DIV_PCLK cycles, HREF = 1 throughout, then hblank.
REQ-025 hblank lasts exactly HBLANK_CICLOS cycles; if line counter < LINHAS-1, increment it and go to linha_ativa; else go to fim.
REQ-026 fim lasts 1 cycle with fim_frame = 1; continuo = 1 -> pulso_vsync, else inicial.
REQ-027 Byte slot counter resets to 0 at entry to linha_ativa; transmite_byte = 1 when slot cycle counter = DIV_PCLK-1; exactly COLUNAS*2 strobes per line, none outside linha_ativa.
REQ-028 padrao = 0: dados = (line*COLUNAS*2 + byte index) mod 256, 8-bit wrap, byte index 0..COLUNAS*2-1.
REQ-029 padrao = 1: even byte index drives cor[15:8], odd drives cor[7:0].
REQ-030 dados = 8'h00 whenever HREF = 0.
REQ-031 padrao changes take effect at the next byte slot boundary; no slot shows a mixed value.
REQ-032 Total frame length = VSYNC_CICLOS + HBLANK_CICLOS + LINHAS*(COLUNAS*2*DIV_PCLK + HBLANK_CICLOS) + 1 cycles.
REQ-033 DIV_PCLK = 1: transmite_byte stays high for the whole linha_ativa and dados changes every cycle.

Reset
REQ-034 reset = 0: state inicial; VSYNC, HREF, transmite_byte, fim_frame, ocupado = 0; dados = 8'h00; db_estado = 0000; all counters = 0.
REQ-035 Reset mid-frame aborts immediately; after release, no output activity until iniciar sampled high.

Verification
REQ-036 Defaults, padrao = 0, iniciar one cycle, continuo = 0 -> VSYNC high 4 cycles; 32 strobes with dados 00..1F in order; HREF high 4 times x 16 cycles; fim_frame exactly 84 cycles after iniciar sampled; back to inicial.
REQ-037 padrao = 1, cor = 16'hF800 -> strobed bytes alternate F8, 00 for all 32 strobes; dados = 00 between lines.
REQ-038 continuo = 1 held -> second VSYNC rises the cycle after fim_frame; iniciar pulses mid-frame have no effect.
REQ-039 reset = 0 asserted during linha_ativa of line 2 -> all outputs 0 in the same cycle, db_estado = 0000; after release with iniciar = 0, outputs stay idle 50 cycles.
REQ-040 LINHAS = 1, COLUNAS = 1, DIV_PCLK = 1 -> 2 consecutive strobes, dados 00 then 01; frame length VSYNC_CICLOS + 2*HBLANK_CICLOS + 3 cycles.
